// File: rtl/uart_io_if.sv
// rtl/uart_io_if.sv - processor port bus between the CPU I/O ports and uart_io
interface uart_io_if;
    logic [7:0] tx_data;
    logic [7:0] ctrl;
    logic [7:0] status;
    logic [7:0] rx_data;

    // CPU side: writes out_p1/out_p2, reads in_p0/in_p1
    modport master (
        output tx_data,
        output ctrl,
        input  status,
        input  rx_data
    );

    // Peripheral side
    modport slave (
        input  tx_data,
        input  ctrl,
        output status,
        output rx_data
    );
endinterface

// File: rtl/uart_io.sv
// rtl/uart_io.sv - toggle-commanded UART on CPU ports, 8N1 or 8E1 when UART_IO_PARITY_EN is defined
module uart_io #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      rxd,
    output logic      txd,
    uart_io_if.slave  bus
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
`ifdef UART_IO_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef UART_IO_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    // Commands are bit toggles, so edges are found against last cycle's value
    logic [1:0] ctrl_q;
    logic       go_evt;
    logic       ack_evt;

    assign go_evt  = bus.ctrl[0] ^ ctrl_q[0];
    assign ack_evt = bus.ctrl[1] ^ ctrl_q[1];

    // Command history register
    always_ff @(posedge clk) begin
        if (reset) ctrl_q <= 2'b00;
        else       ctrl_q <= bus.ctrl[1:0];
    end

    // ---------------- transmitter ----------------
    tx_state_t   tx_state, tx_state_d;
    logic [TW-1:0] tx_timer, tx_timer_d;
    logic [2:0]  tx_bits, tx_bits_d;
    logic [7:0]  tx_shift, tx_shift_d;
    logic        txd_q, txd_d;
    logic        tx_busy, tx_busy_d;
    logic        tx_drop, tx_drop_d;
    logic        tx_tick;
`ifdef UART_IO_PARITY_EN
    logic        tx_par, tx_par_d;
`endif

    assign tx_tick = (tx_timer == BIT_LAST);

    // TX next-state: shift register holds the latched byte, so later tx_data writes are harmless
    always_comb begin
        tx_state_d = tx_state;
        tx_timer_d = tx_timer;
        tx_bits_d  = tx_bits;
        tx_shift_d = tx_shift;
        txd_d      = txd_q;
        tx_busy_d  = tx_busy;
        tx_drop_d  = tx_drop;
`ifdef UART_IO_PARITY_EN
        tx_par_d   = tx_par;
`endif
        if (tx_state != TX_IDLE)
            tx_timer_d = tx_tick ? '0 : tx_timer + 1'b1;
        case (tx_state)
            TX_IDLE: begin
                if (go_evt) begin
                    tx_state_d = TX_START;
                    tx_timer_d = '0;
                    tx_shift_d = bus.tx_data;
                    txd_d      = 1'b0;
                    tx_busy_d  = 1'b1;
                    tx_drop_d  = 1'b0;
`ifdef UART_IO_PARITY_EN
                    tx_par_d   = ^bus.tx_data;
`endif
                end
            end
            TX_START: begin
                if (tx_tick) begin
                    tx_state_d = TX_DATA;
                    tx_bits_d  = 3'd0;
                    txd_d      = tx_shift[0];
                end
            end
            TX_DATA: begin
                if (tx_tick) begin
                    if (tx_bits == 3'd7) begin
`ifdef UART_IO_PARITY_EN
                        tx_state_d = TX_PARITY;
                        txd_d      = tx_par;
`else
                        tx_state_d = TX_STOP;
                        txd_d      = 1'b1;
`endif
                    end else begin
                        tx_bits_d  = tx_bits + 3'd1;
                        tx_shift_d = {1'b0, tx_shift[7:1]};
                        txd_d      = tx_shift[1];
                    end
                end
            end
`ifdef UART_IO_PARITY_EN
            TX_PARITY: begin
                if (tx_tick) begin
                    tx_state_d = TX_STOP;
                    txd_d      = 1'b1;
                end
            end
`endif
            TX_STOP: begin
                if (tx_tick) begin
                    tx_state_d = TX_IDLE;
                    tx_busy_d  = 1'b0;
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                txd_d      = 1'b1;
                tx_busy_d  = 1'b0;
            end
        endcase
        if (go_evt && tx_state != TX_IDLE)
            tx_drop_d = 1'b1;
    end

    // TX state register; reset forces the line idle even mid-frame
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_timer <= '0;
            tx_bits  <= 3'd0;
            tx_shift <= 8'h00;
            txd_q    <= 1'b1;
            tx_busy  <= 1'b0;
            tx_drop  <= 1'b0;
`ifdef UART_IO_PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else begin
            tx_state <= tx_state_d;
            tx_timer <= tx_timer_d;
            tx_bits  <= tx_bits_d;
            tx_shift <= tx_shift_d;
            txd_q    <= txd_d;
            tx_busy  <= tx_busy_d;
            tx_drop  <= tx_drop_d;
`ifdef UART_IO_PARITY_EN
            tx_par   <= tx_par_d;
`endif
        end
    end

    // ---------------- receiver ----------------
    logic        rx_sync1, rx_sync2, rx_prev;
    logic        rx_fall;
    rx_state_t   rx_state, rx_state_d;
    logic [TW-1:0] rx_timer, rx_timer_d;
    logic [2:0]  rx_bits, rx_bits_d;
    logic [7:0]  rx_shift, rx_shift_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid, rx_valid_d;
    logic        rx_overrun, rx_overrun_d;
    logic        rx_ferr, rx_ferr_d;
    logic        rx_tick;
    logic        rx_perr_out;
`ifdef UART_IO_PARITY_EN
    logic        rx_par_bit, rx_par_bit_d;
    logic        rx_perr, rx_perr_d;
`endif

    assign rx_fall = rx_prev & ~rx_sync2;
    assign rx_tick = (rx_timer == BIT_LAST);

    // Synchronizer plus one extra flop for falling-edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_sync1 <= 1'b1;
            rx_sync2 <= 1'b1;
            rx_prev  <= 1'b1;
        end else begin
            rx_sync1 <= rxd;
            rx_sync2 <= rx_sync1;
            rx_prev  <= rx_sync2;
        end
    end

    // RX next-state: ack is applied before a same-cycle delivery so the new byte survives it
    always_comb begin
        rx_state_d   = rx_state;
        rx_timer_d   = rx_timer;
        rx_bits_d    = rx_bits;
        rx_shift_d   = rx_shift;
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid;
        rx_overrun_d = rx_overrun;
        rx_ferr_d    = rx_ferr;
`ifdef UART_IO_PARITY_EN
        rx_par_bit_d = rx_par_bit;
        rx_perr_d    = rx_perr;
`endif
        if (ack_evt) begin
            rx_valid_d   = 1'b0;
            rx_overrun_d = 1'b0;
            rx_ferr_d    = 1'b0;
`ifdef UART_IO_PARITY_EN
            rx_perr_d    = 1'b0;
`endif
        end
        if (rx_state != RX_IDLE && rx_state != RX_WAIT_HIGH)
            rx_timer_d = rx_timer + 1'b1;
        case (rx_state)
            RX_IDLE: begin
                if (rx_fall) begin
                    rx_state_d = RX_START;
                    rx_timer_d = '0;
                end
            end
            RX_START: begin
                if (rx_timer == HALF_LAST) begin
                    rx_timer_d = '0;
                    rx_bits_d  = 3'd0;
                    rx_state_d = rx_sync2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_tick) begin
                    rx_timer_d = '0;
                    rx_shift_d = {rx_sync2, rx_shift[7:1]};
                    if (rx_bits == 3'd7) begin
`ifdef UART_IO_PARITY_EN
                        rx_state_d = RX_PARITY;
`else
                        rx_state_d = RX_STOP;
`endif
                    end else begin
                        rx_bits_d = rx_bits + 3'd1;
                    end
                end
            end
`ifdef UART_IO_PARITY_EN
            RX_PARITY: begin
                if (rx_tick) begin
                    rx_timer_d   = '0;
                    rx_par_bit_d = rx_sync2;
                    rx_state_d   = RX_STOP;
                end
            end
`endif
            RX_STOP: begin
                if (rx_tick) begin
                    rx_timer_d = '0;
                    if (!rx_sync2) begin
                        rx_ferr_d  = 1'b1;
                        rx_state_d = RX_WAIT_HIGH;
                    end else begin
                        rx_state_d = RX_IDLE;
                        if (!rx_valid || ack_evt) begin
                            rx_data_d  = rx_shift;
                            rx_valid_d = 1'b1;
`ifdef UART_IO_PARITY_EN
                            rx_perr_d  = (^rx_shift) ^ rx_par_bit;
`endif
                        end else begin
                            rx_overrun_d = 1'b1;
                        end
                    end
                end
            end
            RX_WAIT_HIGH: begin
                if (rx_sync2)
                    rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // RX state and status registers
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state   <= RX_IDLE;
            rx_timer   <= '0;
            rx_bits    <= 3'd0;
            rx_shift   <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
            rx_ferr    <= 1'b0;
`ifdef UART_IO_PARITY_EN
            rx_par_bit <= 1'b0;
            rx_perr    <= 1'b0;
`endif
        end else begin
            rx_state   <= rx_state_d;
            rx_timer   <= rx_timer_d;
            rx_bits    <= rx_bits_d;
            rx_shift   <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid   <= rx_valid_d;
            rx_overrun <= rx_overrun_d;
            rx_ferr    <= rx_ferr_d;
`ifdef UART_IO_PARITY_EN
            rx_par_bit <= rx_par_bit_d;
            rx_perr    <= rx_perr_d;
`endif
        end
    end

`ifdef UART_IO_PARITY_EN
    assign rx_perr_out = rx_perr;
`else
    assign rx_perr_out = 1'b0;
`endif

    assign txd         = txd_q;
    assign bus.rx_data = rx_data_q;
    assign bus.status  = {2'b00, rx_perr_out, tx_drop, rx_ferr, rx_overrun, rx_valid, tx_busy};

endmodule

// File: tb/tb_uart_io.sv
// tb/tb_uart_io.sv - randomized self-checking bench for uart_io against a frame-level model
module tb_uart_io;

    localparam int CPB = 8;
`ifdef UART_IO_PARITY_EN
    localparam int NBITS = 11;
    localparam bit PAR = 1'b1;
`else
    localparam int NBITS = 10;
    localparam bit PAR = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rxd = 1'b1;
    logic txd;

    uart_io_if bus();

    uart_io #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .reset (reset),
        .rxd   (rxd),
        .txd   (txd),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic       m_valid, m_ovr, m_ferr, m_perr, m_drop;
    logic [7:0] m_data;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] m_status();
        return {2'b00, m_perr, m_drop, m_ferr, m_ovr, m_valid, 1'b0};
    endfunction

    task automatic model_reset();
        m_valid = 0; m_ovr = 0; m_ferr = 0; m_perr = 0; m_drop = 0; m_data = 8'h00;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic check_rx(input string tag);
        check({tag, ".status"}, {24'h0, bus.status}, {24'h0, m_status()});
        check({tag, ".rx_data"}, {24'h0, bus.rx_data}, {24'h0, m_data});
    endtask

    task automatic ack();
        @(negedge clk);
        bus.ctrl[1] = ~bus.ctrl[1];
        m_valid = 0; m_ovr = 0; m_ferr = 0; m_perr = 0;
        idle(2);
    endtask

    // Drive one serial frame on rxd and advance the model by the receive rules
    task automatic rx_frame(input logic [7:0] b, input bit bad_stop, input bit bad_par);
        logic [NBITS-1:0] f;
        f[0] = 1'b0;
        f[8:1] = b;
        if (PAR) f[9] = (^b) ^ bad_par;
        f[NBITS-1] = !bad_stop;
        for (int k = 0; k < NBITS; k++) begin
            @(negedge clk);
            rxd = f[k];
            idle(CPB - 1);
        end
        @(negedge clk);
        rxd = 1'b1;
        idle(2 * CPB);
        if (bad_stop) m_ferr = 1;
        else if (!m_valid) begin
            m_data = b; m_valid = 1; m_perr = PAR && bad_par;
        end else m_ovr = 1;
    endtask

    // Start a transmit and check the whole serialized frame plus busy length
    task automatic tx_frame(input string tag, input logic [7:0] b, input int drop_at, input bit with_ack);
        logic [NBITS-1:0] exp_f, got_f;
        int busy_cnt;
        exp_f[0] = 1'b0;
        exp_f[8:1] = b;
        if (PAR) exp_f[9] = ^b;
        exp_f[NBITS-1] = 1'b1;
        got_f = '0;
        busy_cnt = 0;
        @(negedge clk);
        bus.tx_data = b;
        bus.ctrl[0] = ~bus.ctrl[0];
        m_drop = 0;
        if (with_ack) begin
            bus.ctrl[1] = ~bus.ctrl[1];
            m_valid = 0; m_ovr = 0; m_ferr = 0; m_perr = 0;
        end
        for (int i = 0; i < NBITS * CPB + CPB; i++) begin
            @(negedge clk);
            if (bus.status[0]) busy_cnt++;
            if ((i % CPB) == CPB / 2 && (i / CPB) < NBITS) got_f[i / CPB] = txd;
            if (i == drop_at) begin
                bus.tx_data = ~b;
                bus.ctrl[0] = ~bus.ctrl[0];
                m_drop = 1;
            end
        end
        check({tag, ".frame"}, 32'(got_f), 32'(exp_f));
        check({tag, ".busy_cycles"}, busy_cnt, NBITS * CPB);
        check({tag, ".txd_idle"}, {31'h0, txd}, 32'h1);
        check({tag, ".status"}, {24'h0, bus.status}, {24'h0, m_status()});
    endtask

    initial begin
        logic [7:0] b;
        bit bs, bp;
        bus.tx_data = 8'h00;
        bus.ctrl = 8'h00;
        model_reset();

        // 1: reset and idle
        idle(5);
        reset = 1'b0;
        idle(100);
        check("reset.txd", {31'h0, txd}, 32'h1);
        check_rx("reset");

        // 2: transmit A5 then random bytes, with one dropped go mid-frame
        tx_frame("tx_a5", 8'hA5, -1, 0);
        for (int n = 0; n < 4; n++) begin
            b = 8'($urandom);
            tx_frame("tx_rand", b, (n == 1) ? int'($urandom_range(CPB, NBITS * CPB - 2)) : -1, 0);
        end

        // 3: receive 3C and acknowledge
        rx_frame(8'h3C, 0, 0);
        check_rx("rx_3c");
        ack();
        check_rx("rx_3c_ack");

        // 4: overrun
        rx_frame(8'h11, 0, 0);
        rx_frame(8'h22, 0, 0);
        check_rx("rx_overrun");
        check("rx_overrun.status06", {24'h0, bus.status}, 32'h06);
        ack();
        check_rx("rx_overrun_ack");

        // 5: framing error and glitch rejection
        rx_frame(8'h55, 1, 0);
        check_rx("rx_frame_err");
        @(negedge clk);
        rxd = 1'b0;
        idle(3);
        rxd = 1'b1;
        idle(3 * CPB);
        check_rx("rx_glitch");
        ack();

        // Randomized receive traffic with occasional acks, bad stop and bad parity
        for (int n = 0; n < 12; n++) begin
            b = 8'($urandom);
            bs = ($urandom_range(0, 5) == 0);
            bp = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) ack();
            rx_frame(b, bs, bp);
            check_rx("rx_rand");
        end

        // Simultaneous go and ack with a pending byte
        if (!m_valid) rx_frame(8'($urandom), 0, 0);
        tx_frame("go_ack", 8'($urandom), -1, 1);
        check_rx("go_ack_rx");

        // 6: reset mid-frame forces the line idle on the next edge
        @(negedge clk);
        bus.tx_data = 8'h00;
        bus.ctrl[0] = ~bus.ctrl[0];
        idle(30);
        check("midframe.busy", {31'h0, bus.status[0]}, 32'h1);
        reset = 1'b1;
        @(negedge clk);
        model_reset();
        check("midframe_reset.txd", {31'h0, txd}, 32'h1);
        check_rx("midframe_reset");
        bus.ctrl = 8'h00;
        idle(2);
        reset = 1'b0;
        idle(5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
